// File: rtl/updown_counter_pkg.sv
// Shared encodings for the up/down position counter.
package updown_counter_pkg;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/updown_counter_if.sv
// Control and count bundle between a counter user and the counter.
interface updown_counter_if #(
    parameter int bits = 4
);
    logic            en;
    logic            dir;
    logic            ld;
    logic [bits-1:0] in;
    logic [bits-1:0] out;
    logic            ovf;

    modport master (
        output en, dir, ld, in,
        input  out, ovf
    );

    modport slave (
        input  en, dir, ld, in,
        output out, ovf
    );
endinterface

// File: rtl/updown_counter.sv
// Up/down counter over 0..maxvalue with preset, clear and wrap pulse.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int bits     = 4,
    parameter int maxvalue = 15
) (
    input logic            c,
    input logic            clr,
    updown_counter_if.slave bus
);
    localparam logic [bits-1:0] max_cnt = bits'(maxvalue);
    localparam logic [bits-1:0] one     = bits'(1);

    if (maxvalue < 0 ||
        longint'(maxvalue) > (longint'(1) << bits) - 1) begin : g_bad_range
        $error("updown_counter: maxvalue does not fit in bits");
    end

    logic [bits-1:0] cnt_next;
    logic            wrap;

    // Loaded values above maxvalue wrap to 0 going up, count normally going down.
    always_comb begin
        cnt_next = bus.out;
        wrap     = 1'b0;
        if (bus.ld) begin
            cnt_next = bus.in;
        end else if (bus.en) begin
            if (bus.dir == DIR_UP) begin
                if (bus.out >= max_cnt) begin
                    cnt_next = '0;
                    wrap     = 1'b1;
                end else begin
                    cnt_next = bus.out + one;
                end
            end else begin
                if (bus.out == '0) begin
                    cnt_next = max_cnt;
                    wrap     = 1'b1;
                end else begin
                    cnt_next = bus.out - one;
                end
            end
        end
    end

    always_ff @(posedge c) begin
        if (clr) begin
            bus.out <= '0;
            bus.ovf <= 1'b0;
        end else begin
            bus.out <= cnt_next;
            bus.ovf <= wrap;
        end
    end
endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: full-range unit (max 15) and short-range unit (max 9).
module tb_updown_counter;
    import updown_counter_pkg::*;

    typedef struct {
        bit         sel;
        bit         clr;
        bit         ld;
        bit         en;
        bit         dir;
        logic [3:0] in;
        logic [3:0] eout;
        bit         eovf;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] eout;
        bit         eovf;
        string      name;
    } exp_t;

    logic c = 1'b0;
    logic clr_a, clr_b;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    vec_t tbl[$];

    updown_counter_if #(.bits(4)) bus_a ();
    updown_counter_if #(.bits(4)) bus_b ();

    updown_counter #(.bits(4), .maxvalue(15)) dut_a (
        .c(c), .clr(clr_a), .bus(bus_a)
    );
    updown_counter #(.bits(4), .maxvalue(9)) dut_b (
        .c(c), .clr(clr_b), .bus(bus_b)
    );

    always #5 c = ~c;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, required finish before 100000");
        $fatal(1);
    end

    function automatic vec_t mk(bit sel, bit cl, bit ld, bit en, bit dir,
                                logic [3:0] in, logic [3:0] eo, bit ev,
                                string name);
        vec_t v;
        v.sel = sel; v.clr = cl; v.ld = ld; v.en = en; v.dir = dir;
        v.in = in; v.eout = eo; v.eovf = ev; v.name = name;
        return v;
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        logic [3:0] aout;
        logic       aovf;
        clr_a = 0; bus_a.ld = 0; bus_a.en = 0; bus_a.dir = DIR_UP; bus_a.in = 0;
        clr_b = 0; bus_b.ld = 0; bus_b.en = 0; bus_b.dir = DIR_UP; bus_b.in = 0;
        if (v.sel == 0) begin
            clr_a = v.clr; bus_a.ld = v.ld; bus_a.en = v.en;
            bus_a.dir = v.dir; bus_a.in = v.in;
        end else begin
            clr_b = v.clr; bus_b.ld = v.ld; bus_b.en = v.en;
            bus_b.dir = v.dir; bus_b.in = v.in;
        end
        e.eout = v.eout; e.eovf = v.eovf; e.name = v.name;
        sb.push_back(e);
        @(posedge c);
        #1;
        aout = v.sel ? bus_b.out : bus_a.out;
        aovf = v.sel ? bus_b.ovf : bus_a.ovf;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, out=%0d ovf=%0d", v.name, aout, aovf);
        end else begin
            got = sb.pop_front();
            if (aout !== got.eout || aovf !== got.eovf) begin
                miscompares++;
                $display("FAIL %s: got out=%0d ovf=%0d, expected out=%0d ovf=%0d",
                         got.name, aout, aovf, got.eout, got.eovf);
            end
        end
    endtask

    initial begin
        clr_a = 0; clr_b = 0;
        bus_a.ld = 0; bus_a.en = 0; bus_a.dir = 0; bus_a.in = 0;
        bus_b.ld = 0; bus_b.en = 0; bus_b.dir = 0; bus_b.in = 0;
        @(posedge c);
        #1;

        // Full-range unit, table vectors
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, "clr_a"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, "idle_a0"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4'd7, 4'd0, 0, "idle_a1"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd9, 4'd9, 0, "ld_no_en"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd10, 0, "up_10"));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'd0, 4'd9, 0, "dir_flip"));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd9, 4'd0, 0, "clr_beats_ld"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd9, 4'd9, 0, "ld_alone_9"));
        tbl.push_back(mk(0, 0, 1, 1, 1, 4'd15, 4'd15, 0, "ld_15"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd0, 1, "wrap_up_15"));
        tbl.push_back(mk(0, 1, 0, 1, 0, 4'd0, 4'd0, 0, "clr_kills_ovf"));
        // Short-range unit (maxvalue 9)
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd0, 0, "clr_b"));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'd8, 4'd8, 0, "b_ld8"));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 0, "b_up_9"));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd0, 1, "b_wrap_up"));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'd12, 4'd12, 0, "b_ld12"));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd0, 1, "b_up_over"));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'd12, 4'd12, 0, "b_ld12_again"));
        tbl.push_back(mk(1, 0, 0, 1, 1, 4'd0, 4'd11, 0, "b_down_over"));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd0, 0, "b_clr2"));
        tbl.push_back(mk(1, 0, 0, 1, 1, 4'd0, 4'd9, 1, "b_wrap_down"));
        tbl.push_back(mk(1, 0, 0, 0, 1, 4'd0, 4'd9, 0, "b_idle"));
        tbl.push_back(mk(1, 0, 0, 1, 1, 4'd0, 4'd8, 0, "b_down_8"));
        foreach (tbl[i]) step(tbl[i]);

        // Count up 16 edges from 0 with a single wrap
        step(mk(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, "seq_up_clr"));
        for (int i = 0; i < 16; i++) begin
            logic [3:0] eo;
            eo = 4'((i + 1) % 16);
            step(mk(0, 0, 0, 1, DIR_UP, 4'd0, eo, i == 15, "seq_up"));
        end

        // Held load overrides enable, counting resumes after release
        for (int i = 0; i < 6; i++)
            step(mk(0, 0, 1, 1, DIR_UP, 4'd3, 4'd3, 0, "seq_ld_hold"));
        step(mk(0, 0, 0, 1, DIR_UP, 4'd0, 4'd4, 0, "seq_ld_release"));

        // Count down 16 edges from 3 with a single wrap to 15
        step(mk(0, 0, 1, 0, 0, 4'd3, 4'd3, 0, "seq_dn_ld3"));
        for (int i = 0; i < 16; i++) begin
            logic [3:0] eo;
            eo = 4'((3 - 1 - i + 32) % 16);
            step(mk(0, 0, 0, 1, DIR_DOWN, 4'd0, eo, i == 3, "seq_down"));
        end

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
